// File: rtl/sram_bank_writer.sv
// Round-robin multi-bank write controller for the FPGA-side port of the HPS-shared SRAM.
// Fills equal banks in turn, flags each full bank, and reuses banks once the HPS releases them.
module sram_bank_writer #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_BANKS  = 6,
    parameter int unsigned BANK_WORDS = 2048,
    parameter int unsigned DROP_W     = 16,
    localparam int unsigned BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int unsigned PTR_W     = $clog2(BANK_WORDS),
    localparam int unsigned LVL_W     = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [NUM_BANKS-1:0] bank_release,
    output logic [ADDR_W-1:0]    sram_address,
    output logic                 sram_chipselect,
    output logic                 sram_clken,
    output logic                 sram_write,
    output logic [DATA_W-1:0]    sram_writedata,
    output logic [DATA_W/8-1:0]  sram_byteenable,
    output logic [NUM_BANKS-1:0] bank_full,
    output logic [BANK_W-1:0]    cur_bank,
    output logic [LVL_W-1:0]     fill_level,
    output logic [DROP_W-1:0]    drop_cnt,
    output logic                 overflow
);

    typedef enum logic [1:0] {StIdle, StFill, StStall} state_t;

    state_t               state;
    logic [PTR_W-1:0]     wr_ptr;
    logic [NUM_BANKS-1:0] avail_now, avail_rel, set_mask, full_next;
    logic [BANK_W:0]      idle_pick, fill_pick, stall_pick;
    logic [ADDR_W-1:0]    bank_addr;
    logic                 last_word;

    // Returns {found, index} of the first free bank at start+1 .. start+span (mod NUM_BANKS).
    function automatic logic [BANK_W:0] rr_pick(input logic [NUM_BANKS-1:0] free,
                                                input int start, input int span);
        logic [BANK_W:0]      r;
        logic [NUM_BANKS-1:0] sh;
        int                   idx;
        r = '0;
        for (int i = span; i >= 1; i--) begin
            idx = (start + i) % int'(NUM_BANKS);
            sh  = free >> idx;
            if (sh[0]) r = {1'b1, BANK_W'(idx)};
        end
        return r;
    endfunction

    always_comb begin
        avail_now  = ~bank_full;
        avail_rel  = ~(bank_full & ~bank_release);
        idle_pick  = rr_pick(avail_now, int'(NUM_BANKS) - 1, int'(NUM_BANKS));
        fill_pick  = rr_pick(avail_now, int'(cur_bank), int'(NUM_BANKS) - 1);
        stall_pick = rr_pick(avail_rel, int'(cur_bank), int'(NUM_BANKS));
        last_word  = (wr_ptr == PTR_W'(BANK_WORDS - 1));
        set_mask   = '0;
        if (state == StFill && in_valid && last_word) set_mask = NUM_BANKS'(1) << cur_bank;
        // A set on the same bit as a release wins.
        full_next  = (bank_full & ~bank_release) | set_mask;
        bank_addr  = '0;
        bank_addr[PTR_W +: BANK_W] = cur_bank;
        bank_addr[PTR_W-1:0]       = wr_ptr;
    end

    assign sram_chipselect = sram_write;
    assign sram_byteenable = '1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= StIdle;
            wr_ptr         <= '0;
            cur_bank       <= '0;
            fill_level     <= '0;
            bank_full      <= '0;
            drop_cnt       <= '0;
            overflow       <= 1'b0;
            sram_clken     <= 1'b0;
            sram_write     <= 1'b0;
            sram_address   <= '0;
            sram_writedata <= '0;
        end else begin
            sram_clken <= 1'b1;
            sram_write <= 1'b0;
            bank_full  <= full_next;
            unique case (state)
                StIdle: begin
                    wr_ptr     <= '0;
                    fill_level <= '0;
                    if (en) begin
                        if (idle_pick[BANK_W]) begin
                            state    <= StFill;
                            cur_bank <= idle_pick[BANK_W-1:0];
                        end else begin
                            state <= StStall;
                        end
                    end
                end
                StFill: begin
                    if (in_valid) begin
                        sram_write     <= 1'b1;
                        sram_address   <= bank_addr;
                        sram_writedata <= in_data;
                        if (last_word) begin
                            wr_ptr <= '0;
                            if (fill_pick[BANK_W]) begin
                                cur_bank   <= fill_pick[BANK_W-1:0];
                                fill_level <= '0;
                            end else begin
                                state      <= StStall;
                                fill_level <= LVL_W'(BANK_WORDS);
                            end
                        end else begin
                            wr_ptr     <= wr_ptr + 1'b1;
                            fill_level <= fill_level + 1'b1;
                        end
                    end
                    // Partial bank is abandoned unflagged; the word in this cycle still lands.
                    if (!en) begin
                        state      <= StIdle;
                        wr_ptr     <= '0;
                        fill_level <= '0;
                    end
                end
                StStall: begin
                    if (in_valid) begin
                        overflow <= 1'b1;
                        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
                    end
                    if (!en) begin
                        state <= StIdle;
                    end else if (stall_pick[BANK_W]) begin
                        state      <= StFill;
                        cur_bank   <= stall_pick[BANK_W-1:0];
                        wr_ptr     <= '0;
                        fill_level <= '0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bank_writer.sv
// Directed bench for sram_bank_writer with 3 banks of 4 words and a 4-bit drop counter.
module tb_sram_bank_writer;

    logic        clk, reset_n, en, in_valid;
    logic [15:0] in_data;
    logic [2:0]  bank_release;
    logic [5:0]  sram_address;
    logic        sram_chipselect, sram_clken, sram_write;
    logic [15:0] sram_writedata;
    logic [1:0]  sram_byteenable;
    logic [2:0]  bank_full;
    logic [1:0]  cur_bank;
    logic [2:0]  fill_level;
    logic [3:0]  drop_cnt;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    sram_bank_writer #(
        .ADDR_W(6), .DATA_W(16), .NUM_BANKS(3), .BANK_WORDS(4), .DROP_W(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .in_valid(in_valid), .in_data(in_data),
        .bank_release(bank_release), .sram_address(sram_address),
        .sram_chipselect(sram_chipselect), .sram_clken(sram_clken), .sram_write(sram_write),
        .sram_writedata(sram_writedata), .sram_byteenable(sram_byteenable),
        .bank_full(bank_full), .cur_bank(cur_bank), .fill_level(fill_level),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en, vld;
        logic [15:0] data;
        logic [2:0]  rel;
        logic        wr;
        logic [5:0]  addr;
        logic [2:0]  full;
        logic [1:0]  bank;
        logic [2:0]  fill;
        logic [3:0]  drop;
        logic        ovf;
    } vec_t;

    vec_t tv[34];

    function automatic vec_t mk(int e, int v, int d, int r, int w, int a, int f, int b, int l,
                                int dr, int o);
        vec_t x;
        x.en = 1'(e); x.vld = 1'(v); x.data = 16'(d); x.rel = 3'(r); x.wr = 1'(w);
        x.addr = 6'(a); x.full = 3'(f); x.bank = 2'(b); x.fill = 3'(l); x.drop = 4'(dr);
        x.ovf = 1'(o);
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic e, input logic v, input logic [15:0] d, input logic [2:0] r);
        @(negedge clk);
        en = e; in_valid = v; in_data = d; bank_release = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_write"}, 32'(sram_write), 0);
        chk({tag, "_cs"}, 32'(sram_chipselect), 0);
        chk({tag, "_addr"}, 32'(sram_address), 0);
        chk({tag, "_wdata"}, 32'(sram_writedata), 0);
        chk({tag, "_full"}, 32'(bank_full), 0);
        chk({tag, "_bank"}, 32'(cur_bank), 0);
        chk({tag, "_fill"}, 32'(fill_level), 0);
        chk({tag, "_drop"}, 32'(drop_cnt), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_clken"}, 32'(sram_clken), 0);
        chk({tag, "_be"}, 32'(sram_byteenable), 32'h3);
    endtask

    initial begin
        //         en v  data rel  wr addr full  bank fill drop ovf
        tv[0]  = mk(1, 0, 0,  0,     0, 0,  3'b000, 0, 0, 0, 0);
        tv[1]  = mk(1, 1, 0,  0,     1, 0,  3'b000, 0, 1, 0, 0);
        tv[2]  = mk(1, 1, 1,  0,     1, 1,  3'b000, 0, 2, 0, 0);
        tv[3]  = mk(1, 1, 2,  0,     1, 2,  3'b000, 0, 3, 0, 0);
        tv[4]  = mk(1, 1, 3,  0,     1, 3,  3'b001, 1, 0, 0, 0);
        tv[5]  = mk(1, 1, 4,  0,     1, 4,  3'b001, 1, 1, 0, 0);
        tv[6]  = mk(1, 1, 5,  0,     1, 5,  3'b001, 1, 2, 0, 0);
        tv[7]  = mk(1, 1, 6,  0,     1, 6,  3'b001, 1, 3, 0, 0);
        tv[8]  = mk(1, 1, 7,  0,     1, 7,  3'b011, 2, 0, 0, 0);
        tv[9]  = mk(1, 1, 8,  0,     1, 8,  3'b011, 2, 1, 0, 0);
        tv[10] = mk(1, 1, 9,  0,     1, 9,  3'b011, 2, 2, 0, 0);
        tv[11] = mk(1, 1, 10, 0,     1, 10, 3'b011, 2, 3, 0, 0);
        tv[12] = mk(1, 1, 11, 0,     1, 11, 3'b111, 2, 4, 0, 0);
        tv[13] = mk(1, 1, 12, 0,     0, 0,  3'b111, 2, 4, 1, 1);
        tv[14] = mk(1, 1, 13, 3'b010, 0, 0, 3'b101, 1, 0, 2, 1);
        tv[15] = mk(1, 1, 20, 0,     1, 4,  3'b101, 1, 1, 2, 1);
        tv[16] = mk(1, 1, 21, 0,     1, 5,  3'b101, 1, 2, 2, 1);
        tv[17] = mk(1, 1, 22, 0,     1, 6,  3'b101, 1, 3, 2, 1);
        tv[18] = mk(1, 1, 23, 0,     1, 7,  3'b111, 1, 4, 2, 1);
        tv[19] = mk(1, 0, 0,  3'b011, 0, 0, 3'b100, 0, 0, 2, 1);
        tv[20] = mk(1, 1, 30, 0,     1, 0,  3'b100, 0, 1, 2, 1);
        tv[21] = mk(1, 1, 31, 0,     1, 1,  3'b100, 0, 2, 2, 1);
        tv[22] = mk(1, 1, 32, 0,     1, 2,  3'b100, 0, 3, 2, 1);
        tv[23] = mk(1, 1, 33, 0,     1, 3,  3'b101, 1, 0, 2, 1);
        tv[24] = mk(1, 1, 40, 0,     1, 4,  3'b101, 1, 1, 2, 1);
        tv[25] = mk(1, 1, 41, 3'b001, 1, 5, 3'b100, 1, 2, 2, 1);
        tv[26] = mk(1, 1, 42, 0,     1, 6,  3'b100, 1, 3, 2, 1);
        tv[27] = mk(1, 1, 43, 0,     1, 7,  3'b110, 0, 0, 2, 1);
        tv[28] = mk(1, 1, 50, 0,     1, 0,  3'b110, 0, 1, 2, 1);
        tv[29] = mk(1, 1, 51, 0,     1, 1,  3'b110, 0, 2, 2, 1);
        tv[30] = mk(0, 1, 52, 0,     1, 2,  3'b110, 0, 0, 2, 1);
        tv[31] = mk(0, 1, 53, 0,     0, 0,  3'b110, 0, 0, 2, 1);
        tv[32] = mk(1, 0, 0,  0,     0, 0,  3'b110, 0, 0, 2, 1);
        tv[33] = mk(1, 1, 60, 0,     1, 0,  3'b110, 0, 1, 2, 1);

        reset_n = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0; bank_release = '0;
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 34; i++) begin
            step(tv[i].en, tv[i].vld, tv[i].data, tv[i].rel);
            chk($sformatf("r%0d_write", i), 32'(sram_write), 32'(tv[i].wr));
            chk($sformatf("r%0d_cs", i), 32'(sram_chipselect), 32'(tv[i].wr));
            if (tv[i].wr) begin
                chk($sformatf("r%0d_addr", i), 32'(sram_address), 32'(tv[i].addr));
                chk($sformatf("r%0d_wdata", i), 32'(sram_writedata), 32'(tv[i].data));
            end
            chk($sformatf("r%0d_full", i), 32'(bank_full), 32'(tv[i].full));
            chk($sformatf("r%0d_bank", i), 32'(cur_bank), 32'(tv[i].bank));
            chk($sformatf("r%0d_fill", i), 32'(fill_level), 32'(tv[i].fill));
            chk($sformatf("r%0d_drop", i), 32'(drop_cnt), 32'(tv[i].drop));
            chk($sformatf("r%0d_ovf", i), 32'(overflow), 32'(tv[i].ovf));
            if (i == 0) chk("clken_after_reset", 32'(sram_clken), 1);
        end

        // Finish bank 0 (words 61..63 at offsets 1..3); all banks are then full.
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b1, 16'(60 + k), 3'b000);
            chk($sformatf("tail%0d_addr", k), 32'(sram_address), 32'(k));
        end
        chk("tail_full", 32'(bank_full), 32'h7);

        // 20 more drops from a count of 2 saturate the 4-bit counter.
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 16'(100 + k), 3'b000);
        chk("sat_drop", 32'(drop_cnt), 32'hf);
        chk("sat_ovf", 32'(overflow), 1);
        chk("sat_nowrite", 32'(sram_write), 0);

        // Free bank 0, write one word, then reset while the strobe is high.
        step(1'b1, 1'b0, 16'h0, 3'b001);
        chk("rel_full", 32'(bank_full), 32'h6);
        step(1'b1, 1'b1, 16'h70, 3'b000);
        chk("pre_rst_write", 32'(sram_write), 1);
        chk("pre_rst_addr", 32'(sram_address), 0);
        reset_n = 1'b0;
        #1 chk_reset_vals("async");
        @(negedge clk);
        reset_n = 1'b1; en = 1'b0; in_valid = 1'b0;
        chk("clken_pre_edge", 32'(sram_clken), 0);
        @(posedge clk);
        #1 chk("clken_post_edge", 32'(sram_clken), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
